// File: rtl/unsigned_mult_5x5.sv
// Registered unsigned multiplier: input register, explicit AND-array with
// ripple-carry adder rows, output register. Fixed two-cycle latency.
module unsigned_mult_5x5 #(
  parameter int WIDTH_A = 5,
  parameter int WIDTH_B = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH_A-1:0]         dataa,
  input  logic [WIDTH_B-1:0]         datab,
  output logic [WIDTH_A+WIDTH_B-1:0] dataout
);

  logic [WIDTH_A-1:0]         r_a_q;
  logic [WIDTH_B-1:0]         r_b_q;
  logic [WIDTH_A+WIDTH_B-1:0] w_prod;

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q <= '0;
      r_b_q <= '0;
    end else begin
      r_a_q <= dataa;
      r_b_q <= datab;
    end
  end

  // Each row's LSB is a finished product bit; the upper WIDTH_A bits carry
  // forward as the addend for the next partial-product row.
  for (genvar j = 0; j < WIDTH_B; j++) begin : g_row
    logic [WIDTH_A-1:0] w_pp;
    logic [WIDTH_A:0]   w_sum;

    assign w_pp = r_a_q & {WIDTH_A{r_b_q[j]}};

    if (j == 0) begin : g_first
      assign w_sum = {1'b0, w_pp};
    end else begin : g_add
      logic [WIDTH_A-1:0] w_x;
      assign w_x = g_row[j-1].w_sum[WIDTH_A:1];

      always_comb begin
        logic c;
        w_sum = '0;
        c     = 1'b0;
        for (int i = 0; i < WIDTH_A; i++) begin
          w_sum[i] = w_x[i] ^ w_pp[i] ^ c;
          c        = (w_x[i] & w_pp[i]) | (c & (w_x[i] ^ w_pp[i]));
        end
        w_sum[WIDTH_A] = c;
      end
    end

    assign w_prod[j] = w_sum[0];
  end

  assign w_prod[WIDTH_A+WIDTH_B-1:WIDTH_B] = g_row[WIDTH_B-1].w_sum[WIDTH_A:1];

  // Stage 2: product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dataout <= '0;
    else        dataout <= w_prod;
  end

endmodule

// File: tb/tb_unsigned_mult_5x5.sv
// Randomized and directed bench for unsigned_mult_5x5 against a queue-based
// model: each product emerges two falling edges after its operands are driven.
module tb_unsigned_mult_5x5;

  logic       clk;
  logic       rst_n;
  logic [4:0] dataa;
  logic [4:0] datab;
  logic [9:0] dataout;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_q[$];

  unsigned_mult_5x5 #(.WIDTH_A(5), .WIDTH_B(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dataa   (dataa),
    .datab   (datab),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: check the product due now, then drive the next operand pair.
  task automatic cycle(input string tag, input int a, input int b);
    int exp;
    @(negedge clk);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check_eq(tag, int'(dataout), exp);
    dataa = 5'(a);
    datab = 5'(b);
    exp_q.push_back(a * b);
  endtask

  // Reset pulse between rising edges; stage 1 and output both clear.
  task automatic pulse_reset(input int hold_cycles);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async", int'(dataout), 0);
    dataa = 5'd0;
    datab = 5'd0;
    for (int k = 0; k < hold_cycles; k++) begin
      @(posedge clk);
      #1 check_eq("rst_hold", int'(dataout), 0);
    end
    #1 rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b;
    rst_n = 1'b0;
    dataa = 5'd31;
    datab = 5'd31;
    #1 check_eq("rst_init", int'(dataout), 0);
    repeat (2) @(posedge clk);
    #1 check_eq("rst_init_hold", int'(dataout), 0);
    #1 rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(0);

    cycle("post_rst0", 31, 31);
    cycle("post_rst1", 31, 31);
    cycle("post_rst2", 0, 0);

    cycle("zero", 0, 31);
    cycle("zero", 31, 0);
    cycle("zero", 31, 1);
    cycle("zero", 1, 31);
    cycle("ident", 31, 31);
    cycle("ident", 16, 16);
    cycle("corner", 17, 12);
    cycle("corner", 3, 5);
    cycle("corner", 7, 9);
    cycle("order", 31, 2);
    cycle("order", 0, 0);
    cycle("order", 0, 0);
    cycle("order", 25, 25);

    pulse_reset(0);
    cycle("post_mid0", 3, 3);
    cycle("post_mid1", 0, 0);
    cycle("post_mid2", 0, 0);

    pulse_reset(2);
    cycle("post_long0", 0, 0);
    cycle("post_long1", 0, 0);

    for (int n = 0; n < 100; n++) begin
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      if (n == 0) begin
        a = 31;
        b = 31;
      end
      cycle("rand", a, b);
      cycle("rand", a, b);
    end
    cycle("drain", 0, 0);
    cycle("drain", 0, 0);
    cycle("drain", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
